// File: rtl/iir_sweep_ctrl.sv
// Sweeps IIR coefficient index 0..NIDX-1 (flush, settle, integrate |dout|) and reports the strongest index.
// Define IIR_SWEEP_LOCK_EN to park iir_idx on best_idx after a completed sweep.
`timescale 1ns/1ps
module iir_sweep_ctrl #(
  parameter  int NIDX     = 20,
  parameter  int DW       = 20,
  parameter  int FLUSH    = 4,
  parameter  int SETTLE   = 256,
  parameter  int ACC_LOG2 = 8,
  localparam int IW       = (NIDX > 1) ? $clog2(NIDX) : 1,
  localparam int AW       = DW + ACC_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 smp_vld,
  input  logic signed [DW-1:0] iir_dout,
  output logic [31:0]          iir_idx,
  output logic                 iir_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        best_idx,
  output logic [AW-1:0]        best_mag
);

  localparam int NACC = 1 << ACC_LOG2;
  localparam int CMAX = (FLUSH > SETTLE) ? ((FLUSH > NACC) ? FLUSH : NACC)
                                         : ((SETTLE > NACC) ? SETTLE : NACC);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_SETTLE, S_ACC, S_CMP, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_acc, w_acc_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [IW-1:0] r_best_idx, w_best_idx_nxt;
  logic [AW-1:0] r_best_mag, w_best_mag_nxt;
  logic          r_rst_n, w_rst_n_nxt;

  logic          w_is_min;
  logic [DW-1:0] w_abs;

  // The most negative sample has no positive twin; clamp it to the largest positive value.
  assign w_is_min = (iir_dout == {1'b1, {(DW-1){1'b0}}});
  assign w_abs    = w_is_min     ? {1'b0, {(DW-1){1'b1}}} :
                    iir_dout[DW-1] ? (~iir_dout + 1'b1)   : iir_dout;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_acc_nxt      = r_acc;
    w_idx_nxt      = r_idx;
    w_best_idx_nxt = r_best_idx;
    w_best_mag_nxt = r_best_mag;
    w_rst_n_nxt    = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_FLUSH;
          w_cnt_nxt      = '0;
          w_acc_nxt      = '0;
          w_idx_nxt      = '0;
          w_best_idx_nxt = '0;
          w_best_mag_nxt = '0;
          w_rst_n_nxt    = 1'b0;
        end
      end
      S_FLUSH: begin
        if (r_cnt == CW'(FLUSH - 1)) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_rst_n_nxt = 1'b0;
        end
      end
      S_SETTLE: begin
        if (smp_vld) begin
          if (r_cnt == CW'(SETTLE - 1)) begin
            w_state_nxt = S_ACC;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_ACC: begin
        if (smp_vld) begin
          w_acc_nxt = r_acc + {{ACC_LOG2{1'b0}}, w_abs};
          if (r_cnt == CW'(NACC - 1)) begin
            w_state_nxt = S_CMP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_CMP: begin
        // Strict compare so equal magnitudes keep the earlier index.
        if (r_acc > r_best_mag) begin
          w_best_mag_nxt = r_acc;
          w_best_idx_nxt = r_idx;
        end
        if (r_idx == IW'(NIDX - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = S_FLUSH;
          w_rst_n_nxt = 1'b0;
        end
      end
      S_DONE: begin
`ifdef IIR_SWEEP_LOCK_EN
        w_idx_nxt = r_best_idx;
`else
        w_idx_nxt = r_idx;
`endif
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort freezes index and results where they stand and releases the filter.
    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_acc_nxt      = r_acc;
      w_idx_nxt      = r_idx;
      w_best_idx_nxt = r_best_idx;
      w_best_mag_nxt = r_best_mag;
      w_rst_n_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_mag <= '0;
      r_rst_n    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_idx      <= w_idx_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_best_mag <= w_best_mag_nxt;
      r_rst_n    <= w_rst_n_nxt;
    end
  end

  assign iir_idx   = {{(32-IW){1'b0}}, r_idx};
  assign iir_rst_n = r_rst_n;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign best_idx  = r_best_idx;
  assign best_mag  = r_best_mag;

endmodule
